colpar_theta_engine: RTL and testbench

//  Parametrised column-parity (theta) engine. Successor of the fixed 64x25 column-parity controller.

---
 rtl/colpar_pkg.sv | 48 ++++
 rtl/colpar_theta_dp.sv | 56 +++++
 rtl/colpar_theta_engine.sv | 96 +++++++++
 tb/tb_colpar_theta_engine.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/colpar_pkg.sv
// colpar_pkg: shared types, defaults and column-parity/theta helpers for the colpar theta engine.
// Helpers work on a MAX_DIM*MAX_DIM-bit container so any DIM <= MAX_DIM can reuse them; callers
// zero-extend their slice and keep the low DIM / DIM*DIM result bits.
package colpar_pkg;

    typedef enum logic [2:0] {IDLE, START, PRE_RD, PRE_LD, RD, LD, OUT, DONE} state_t;

    localparam int DEF_DIM   = 5;
    localparam int DEF_DEPTH = 64;
    localparam int MAX_DIM   = 8;
    localparam int MAX_W     = MAX_DIM * MAX_DIM;
    localparam int IW        = $clog2(MAX_W);
    localparam int CW        = $clog2(MAX_DIM);

    // C[x] = XOR over y of lane (x,y), lane (x,y) living at bit x+dim*y
    function automatic logic [MAX_DIM-1:0] col_parity(input logic [MAX_W-1:0] slice, input int dim);
        logic [MAX_DIM-1:0] c;
        int i;
        c = '0;
        for (int y = 0; y < MAX_DIM; y++)
            for (int x = 0; x < MAX_DIM; x++)
                if (x < dim && y < dim) begin
                    i = x + dim * y;
                    c[x[CW-1:0]] = c[x[CW-1:0]] ^ slice[i[IW-1:0]];
                end
        return c;
    endfunction

    // out(x,y) = in(x,y) ^ C_cur[x-1] ^ C_prev[x+1], x indices taken mod dim
    function automatic logic [MAX_W-1:0] theta(input logic [MAX_W-1:0] slice,
                                               input logic [MAX_DIM-1:0] c_cur,
                                               input logic [MAX_DIM-1:0] c_prev,
                                               input int dim);
        logic [MAX_W-1:0] r;
        int i, l, h;
        r = '0;
        for (int y = 0; y < MAX_DIM; y++)
            for (int x = 0; x < MAX_DIM; x++)
                if (x < dim && y < dim) begin
                    i = x + dim * y;
                    l = (x + dim - 1) % dim;
                    h = (x + 1) % dim;
                    r[i[IW-1:0]] = slice[i[IW-1:0]] ^ c_cur[l[CW-1:0]] ^ c_prev[h[CW-1:0]];
                end
        return r;
    endfunction

endpackage

// File: rtl/colpar_theta_dp.sv
// colpar_theta_dp: slice / C_cur / C_prev registers plus combinational theta.
//  clk, rst (async, active-low)  clock and reset
//  ld_prev   capture column parity of rd_data into C_prev
//  ld_cur    capture rd_data into slice and its parity into C_cur
//  adv       shift C_cur into C_prev (beat accepted)
//  out_en    gate for out_data (zero when low)
//  rd_data   memory read data, out_data theta result, c_cur current column parity
module colpar_theta_dp
    import colpar_pkg::*;
#(
    parameter int DIM = DEF_DIM,
    localparam int W  = DIM * DIM
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ld_prev,
    input  logic           ld_cur,
    input  logic           adv,
    input  logic           out_en,
    input  logic [W-1:0]   rd_data,
    output logic [W-1:0]   out_data,
    output logic [DIM-1:0] c_cur
);

    logic [W-1:0]       slice;
    logic [DIM-1:0]     c_prev;
    logic [MAX_DIM-1:0] c_full;
    logic [MAX_W-1:0]   t_full;
    logic               unused_bits;

    always_comb begin
        c_full   = col_parity(MAX_W'(rd_data), DIM);
        t_full   = theta(MAX_W'(slice), MAX_DIM'(c_cur), MAX_DIM'(c_prev), DIM);
        out_data = out_en ? t_full[W-1:0] : '0;
    end

    // upper container bits are always zero for DIM < MAX_DIM
    assign unused_bits = ^{c_full, t_full};

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            slice  <= '0;
            c_cur  <= '0;
            c_prev <= '0;
        end else begin
            if (ld_cur) begin
                slice <= rd_data;
                c_cur <= c_full[DIM-1:0];
            end
            if (ld_prev)
                c_prev <= c_full[DIM-1:0];
            else if (adv)
                c_prev <= c_cur;
        end

endmodule

// File: rtl/colpar_theta_engine.sv
// colpar_theta_engine: streams DEPTH slices from sync-read memory through Keccak theta.
//  clk, rst (async, active-low); start level request, run begins on its falling edge
//  ready idle, done one-cycle completion pulse
//  rd_en/rd_addr/rd_data  memory port, data valid one cycle after rd_en
//  out_valid/out_ready/out_data/out_idx  output stream with back-pressure
//  COLPAR_PARITY_OUT_EN: adds par_out (C_cur of the current beat, zero when out_valid=0)
module colpar_theta_engine
    import colpar_pkg::*;
#(
    parameter int DIM        = DEF_DIM,
    parameter int DEPTH      = DEF_DEPTH,
    localparam int W         = DIM * DIM,
    localparam int ADDR_W    = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [W-1:0]      rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
`ifdef COLPAR_PARITY_OUT_EN
    output logic [DIM-1:0]    par_out,
`endif
    output logic [ADDR_W-1:0] out_idx
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state, nxt;
    logic [ADDR_W-1:0] z;
    logic [DIM-1:0]    c_cur;
    logic              accept;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            z <= '0;
        else if (state == PRE_LD)
            z <= '0;
        else if (accept && z != LAST)
            z <= z + 1'b1;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? START : IDLE;
            START:   nxt = start ? START : PRE_RD;
            PRE_RD:  nxt = PRE_LD;
            PRE_LD:  nxt = RD;
            RD:      nxt = LD;
            LD:      nxt = OUT;
            OUT:     nxt = !out_ready ? OUT : (z == LAST) ? DONE : RD;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // PRE_RD fetches slice DEPTH-1 so slice 0 sees its wrapped predecessor parity
    always_comb begin
        accept    = state == OUT && out_ready;
        ready     = state == IDLE;
        done      = state == DONE;
        rd_en     = state == PRE_RD || state == RD;
        rd_addr   = state == PRE_RD ? LAST :
                    (state == RD || state == LD || state == OUT) ? z : '0;
        out_valid = state == OUT;
        out_idx   = out_valid ? z : '0;
    end

`ifdef COLPAR_PARITY_OUT_EN
    assign par_out = out_valid ? c_cur : '0;
`endif

    colpar_theta_dp #(.DIM(DIM)) dp (
        .clk      (clk),
        .rst      (rst),
        .ld_prev  (state == PRE_LD),
        .ld_cur   (state == LD),
        .adv      (accept),
        .out_en   (out_valid),
        .rd_data  (rd_data),
        .out_data (out_data),
        .c_cur    (c_cur)
    );

endmodule

// File: tb/tb_colpar_theta_engine.sv
// tb_colpar_theta_engine: directed runs with a beat scoreboard against an independent theta model.
module tb_colpar_theta_engine;

    localparam int DIM   = 5;
    localparam int DEPTH = 4;
    localparam int W     = 25;
    localparam int AW    = 2;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [W-1:0]  data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic          ready, done, rd_en, out_valid;
    logic [AW-1:0] rd_addr, out_idx;
    logic [W-1:0]  rd_data = '0;
    logic [W-1:0]  out_data;
`ifdef COLPAR_PARITY_OUT_EN
    logic [DIM-1:0] par_out;
`endif

    logic [W-1:0] mem     [DEPTH];
    logic [W-1:0] exp_tab [DEPTH];
    beat_t        sb [$];
    int           tests = 0;
    int           fails = 0;

    colpar_theta_engine #(.DIM(DIM), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef COLPAR_PARITY_OUT_EN
        .par_out   (par_out),
`endif
        .out_idx   (out_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rd_en)
            rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DIM-1:0] par(input logic [W-1:0] s);
        return s[4:0] ^ s[9:5] ^ s[14:10] ^ s[19:15] ^ s[24:20];
    endfunction

    // D[x] = C[x-1] ^ Cprev[x+1] as rotations, then XORed into every row
    function automatic logic [W-1:0] model(input int z);
        logic [DIM-1:0] c, p, d;
        c = par(mem[z]);
        p = par(mem[(z + DEPTH - 1) % DEPTH]);
        d = {c[3:0], c[4]} ^ {p[0], p[4:1]};
        return mem[z] ^ {5{d}};
    endfunction

    task automatic randomize_mem();
        for (int z = 0; z < DEPTH; z++) begin
            mem[z]     = W'($urandom);
        end
        for (int z = 0; z < DEPTH; z++) exp_tab[z] = model(z);
    endtask

    task automatic run(input string tag, input int hold, input int stall_idx, input int abort_idx);
        int           lat = 0;
        int           bad = 0;
        int           sbad = 0;
        int           early = 0;
        bit           stalled = 1'b0;
        logic [W-1:0] hd;
        logic [AW-1:0] hi;
        beat_t        e;
        for (int z = 0; z < DEPTH; z++) sb.push_back(beat_t'({AW'(z), exp_tab[z]}));
        start = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            early += int'(rd_en);
        end
        chk({tag, " rd_en during start"}, early, 0);
        start = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (!out_valid && out_data != '0) bad++;
            if (out_valid && int'(out_idx) == abort_idx) begin
                rst = 1'b0;
                #1;
                chk({tag, " rst ready"}, ready, 1);
                chk({tag, " rst out_valid"}, out_valid, 0);
                chk({tag, " rst rd_en"}, rd_en, 0);
                chk({tag, " rst done"}, done, 0);
                #1;
                rst = 1'b1;
                sb.delete();
                return;
            end
            if (out_valid && out_ready) begin
                e = sb.size() > 0 ? sb.pop_front() : '1;
                chk({tag, " idx"}, out_idx, e.idx);
                chk({tag, " data"}, out_data, e.data);
`ifdef COLPAR_PARITY_OUT_EN
                chk({tag, " par_out"}, par_out, par(mem[out_idx]));
`endif
                if (int'(out_idx) == stall_idx && !stalled) begin
                    stalled   = 1'b1;
                    hd        = out_data;
                    hi        = out_idx;
                    out_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        lat++;
                        sbad += int'(!out_valid || out_data != hd || out_idx != hi || rd_en);
                    end
                    chk({tag, " stall hold"}, sbad, 0);
                    out_ready = 1'b1;
                end
            end
        end
        chk({tag, " latency"}, lat, stall_idx >= 0 ? 20 : 15);
        chk({tag, " leftover beats"}, sb.size(), 0);
        chk({tag, " data zero when idle"}, bad, 0);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " ready after"}, ready, 1);
    endtask

    initial begin
        for (int z = 0; z < DEPTH; z++) begin
            mem[z]     = '0;
            exp_tab[z] = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset ready", ready, 1);
        chk("reset done", done, 0);
        chk("reset rd_en", rd_en, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset rd_addr", rd_addr, 0);
        rst = 1'b1;
        @(negedge clk);
        run("zero", 1, -1, -1);
        mem[0]  = 25'h0000001;
        exp_tab = '{25'h0210843, 25'h1084210, 25'h0, 25'h0};
        run("slice0", 1, -1, -1);
        mem[0]  = '0;
        mem[3]  = 25'h0000001;
        exp_tab = '{25'h1084210, 25'h0, 25'h0, 25'h0210843};
        run("wrap", 1, -1, -1);
        randomize_mem();
        run("stall", 1, 1, -1);
        randomize_mem();
        run("abort", 1, -1, 2);
        @(negedge clk);
        run("rerun", 1, -1, -1);
        randomize_mem();
        run("hold", 10, -1, -1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
